// File: rtl/dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : dcache_direct_mapped
// Brief    : Direct-mapped write-back/write-allocate data cache, 8-bit cpu
//            port, 4-byte block memory port. DCACHE_STATS_EN adds hit/miss
//            counters.
// Revision : 1.0
// ============================================================================
module dcache_direct_mapped #(
    parameter int INDEX_BITS  = 3,
    parameter int BLOCK_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
`ifdef DCACHE_STATS_EN
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
`endif
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    localparam int c_tag_w   = 8 - 2 - INDEX_BITS;
    localparam int c_lines   = 1 << INDEX_BITS;
    localparam int c_block_w = BLOCK_BYTES * 8;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WRITE_BACK = 2'd1,
        S_FETCH      = 2'd2,
        S_UPDATE     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [5:0]             mem_address_q, mem_address_d;
    logic [31:0]            mem_writedata_q, mem_writedata_d;
    logic [c_lines-1:0]     valid_q, valid_d;
    logic [c_lines-1:0]     dirty_q, dirty_d;
    logic [c_tag_w-1:0]     tag_q  [c_lines];
    logic [c_tag_w-1:0]     tag_d  [c_lines];
    logic [c_block_w-1:0]   data_q [c_lines];
    logic [c_block_w-1:0]   data_d [c_lines];

    logic [INDEX_BITS-1:0]  w_index;
    logic [c_tag_w-1:0]     w_tag;
    logic [1:0]             w_offset;
    logic [c_block_w-1:0]   w_line;
    logic                   w_req, w_hit, w_idle;

    assign w_index  = ADDRESS[2 +: INDEX_BITS];
    assign w_tag    = ADDRESS[7 -: c_tag_w];
    assign w_offset = ADDRESS[1:0];
    assign w_line   = data_q[w_index];
    assign w_req    = READ | WRITE;
    assign w_hit    = valid_q[w_index] && (tag_q[w_index] == w_tag);
    assign w_idle   = (state_q == S_IDLE);

    assign BUSYWAIT      = !w_idle || (w_req && !w_hit);
    assign READDATA      = (w_idle && w_hit) ? w_line[{w_offset, 3'b000} +: 8] : 8'h00;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

    always_comb begin
        state_d         = state_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        tag_d           = tag_q;
        data_d          = data_q;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        if (WRITE) begin
                            data_d[w_index][{w_offset, 3'b000} +: 8] = WRITEDATA;
                            dirty_d[w_index] = 1'b1;
                        end
                    end else if (valid_q[w_index] && dirty_q[w_index]) begin
                        state_d         = S_WRITE_BACK;
                        mem_write_d     = 1'b1;
                        mem_address_d   = {tag_q[w_index], w_index};
                        mem_writedata_d = w_line;
                    end else begin
                        state_d       = S_FETCH;
                        mem_read_d    = 1'b1;
                        mem_address_d = ADDRESS[7:2];
                    end
                end
            end
            S_WRITE_BACK: begin
                if (!mem_busywait) begin
                    state_d         = S_FETCH;
                    mem_write_d     = 1'b0;
                    mem_writedata_d = '0;
                    mem_read_d      = 1'b1;
                    mem_address_d   = ADDRESS[7:2];
                end
            end
            S_FETCH: begin
                // Block is captured on the completing edge, while the memory
                // still presents it; UPDATE is then a pure settle cycle.
                if (!mem_busywait) begin
                    state_d          = S_UPDATE;
                    mem_read_d       = 1'b0;
                    mem_address_d    = '0;
                    data_d[w_index]  = mem_readdata;
                    tag_d[w_index]   = w_tag;
                    valid_d[w_index] = 1'b1;
                    dirty_d[w_index] = 1'b0;
                end
            end
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= S_IDLE;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            valid_q         <= '0;
            dirty_q         <= '0;
        end else begin
            state_q         <= state_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;
    logic        post_fill_q, post_fill_d;

    // The IDLE cycle right after a fill re-evaluates an already counted access.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        post_fill_d  = (state_q == S_UPDATE);
        if (w_idle && w_req && !post_fill_q) begin
            if (w_hit) begin
                if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            post_fill_q  <= 1'b0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            post_fill_q  <= post_fill_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_direct_mapped
// Brief    : Scoreboard bench for dcache_direct_mapped against a transparent
//            byte-memory model with cache-occupancy bookkeeping.
// Revision : 1.0
// ============================================================================
module tb_dcache_direct_mapped;

    logic        CLK = 1'b0;
    logic        RESET, READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic        BUSYWAIT, mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    always #5 CLK = ~CLK;

    dcache_direct_mapped dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
`ifdef DCACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    typedef struct { bit is_read; logic [7:0] data; int stall; } cpu_exp_t;
    typedef struct { bit is_write; logic [5:0] addr; logic [31:0] data; } mem_exp_t;
    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    function automatic logic [31:0] init_word(input logic [5:0] b);
        if (b == 6'h23) return 32'hDDCCBBAA;
        return {b, 2'b11, ~b, 2'b01, b ^ 6'h15, 2'b10, b + 6'd7, 2'b00};
    endfunction

    // Block memory: latency lat cycles, busywait falls in the last cycle.
    int          lat  = 5;
    int          mcnt = 0;
    logic [31:0] mem_arr   [64];
    bit          mem_valid [64];
    assign mem_busywait = (mem_read || mem_write) && (mcnt < lat - 1);
    assign mem_readdata = mem_valid[mem_address] ? mem_arr[mem_address] : init_word(mem_address);
    always @(posedge CLK) begin
        if (!(mem_read || mem_write)) mcnt <= 0;
        else if (mcnt >= lat - 1) begin
            mcnt <= 0;
            if (mem_write) begin
                mem_arr[mem_address]   <= mem_writedata;
                mem_valid[mem_address] <= 1'b1;
            end
        end else mcnt <= mcnt + 1;
    end

    // Reference: the cache is transparent, so loads return the byte-memory
    // view; occupancy arrays only predict hits, stalls and memory traffic.
    logic [7:0]  shadow   [256];
    logic [31:0] ref_back [64];
    bit          mv [8];
    bit          md [8];
    logic [2:0]  mt [8];
    int          m_hits = 0;
    int          m_miss = 0;

    task automatic model_access(input bit wr, input logic [7:0] a, input logic [7:0] d);
        int          idx;
        logic [5:0]  victim;
        logic [31:0] blk;
        cpu_exp_t    ce;
        mem_exp_t    me;
        idx = int'(a[4:2]);
        ce.stall = 0;
        if (mv[idx] && mt[idx] == a[7:5]) m_hits++;
        else begin
            m_miss++;
            if (mv[idx] && md[idx]) begin
                victim = {mt[idx], a[4:2]};
                for (int b = 0; b < 4; b++) blk[b*8 +: 8] = shadow[{victim, 2'(b)}];
                me.is_write = 1'b1; me.addr = victim; me.data = blk;
                mem_q.push_back(me);
                ref_back[victim] = blk;
                ce.stall = 2 * lat + 2;
            end else ce.stall = lat + 2;
            me.is_write = 1'b0; me.addr = a[7:2]; me.data = '0;
            mem_q.push_back(me);
            mv[idx] = 1'b1; mt[idx] = a[7:5]; md[idx] = 1'b0;
        end
        if (wr) begin
            shadow[a] = d;
            md[idx]   = 1'b1;
        end
        ce.is_read = !wr;
        ce.data    = shadow[a];
        cpu_q.push_back(ce);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            if (mv[i] && md[i])
                for (int b = 0; b < 4; b++)
                    shadow[{mt[i], 3'(i), 2'(b)}] = ref_back[{mt[i], 3'(i)}][b*8 +: 8];
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    // cpu-side monitor
    int       stall = 0;
    cpu_exp_t ce_m;
    always @(negedge CLK) begin
        if (RESET) stall = 0;
        else if (READ || WRITE) begin
            if (BUSYWAIT) stall++;
            else begin
                if (cpu_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL cpu_unexpected: got completion at %0h expected none", ADDRESS);
                end else begin
                    ce_m = cpu_q.pop_front();
                    if (ce_m.is_read) chk("readdata", {24'h0, READDATA}, {24'h0, ce_m.data});
                    chk("stall_cycles", stall, ce_m.stall);
                end
                stall = 0;
            end
        end
    end

    // memory-side monitor
    mem_exp_t me_m;
    always @(negedge CLK) begin
        if (!RESET && (mem_read || mem_write) && !mem_busywait) begin
            chk("mem_exclusive", {31'h0, mem_read && mem_write}, 32'h0);
            if (mem_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL mem_unexpected: got transfer at %0h expected none", mem_address);
            end else begin
                me_m = mem_q.pop_front();
                chk("mem_kind", {31'h0, mem_write}, {31'h0, me_m.is_write});
                chk("mem_address", {26'h0, mem_address}, {26'h0, me_m.addr});
                if (me_m.is_write) chk("mem_writedata", mem_writedata, me_m.data);
            end
        end
    end

    task automatic do_access(input bit wr, input bit rd_too, input logic [7:0] a, input logic [7:0] d);
        model_access(wr, a, d);
        READ = wr ? rd_too : 1'b1;
        WRITE = wr;
        ADDRESS = a;
        WRITEDATA = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                @(posedge CLK); #1;
                return;
            end
        end
        fails++;
        $display("FAIL access_timeout: got BUSYWAIT stuck at addr %0h expected release", a);
        summary();
    endtask

    task automatic idle();
        READ = 1'b0;
        WRITE = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #300000;
        fails++;
        $display("FAIL watchdog: got no completion expected finish");
        summary();
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  a, d;
        bit          wr, rd;
        bit          seen;
        for (int i = 0; i < 256; i++) begin
            w = init_word(6'(i >> 2));
            shadow[i] = w[(i % 4) * 8 +: 8];
        end
        for (int i = 0; i < 64; i++) ref_back[i] = init_word(6'(i));
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst_busywait", {31'h0, BUSYWAIT}, 32'h0);
        chk("rst_readdata", {24'h0, READDATA}, 32'h0);
        chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_mem_address", {26'h0, mem_address}, 32'h0);
        chk("rst_mem_writedata", mem_writedata, 32'h0);
        @(posedge CLK); #1;

        lat = 5;
        do_access(1'b0, 1'b0, 8'h8C, 8'h00);
        do_access(1'b0, 1'b0, 8'h8D, 8'h00);
        do_access(1'b1, 1'b0, 8'h8C, 8'h04);
        do_access(1'b1, 1'b0, 8'hAC, 8'h11);
        idle();
`ifdef DCACHE_STATS_EN
        @(negedge CLK);
        chk("hit_count_directed", {16'h0, hit_count}, 32'd2);
        chk("miss_count_directed", {16'h0, miss_count}, 32'd2);
        @(posedge CLK); #1;
`endif
        do_access(1'b0, 1'b0, 8'hAC, 8'h00);
        do_access(1'b0, 1'b0, 8'h4C, 8'h00);
        do_access(1'b0, 1'b0, 8'h0C, 8'h00);
        idle();

        // Abort a clean fetch with RESET.
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h2C;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge CLK);
            seen = mem_read;
        end
        chk("abort_fetch_started", {31'h0, seen}, 32'h1);
        @(posedge CLK); #1;
        RESET = 1'b1; READ = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort_mem_read", {31'h0, mem_read}, 32'h0);
        chk("abort_busywait", {31'h0, BUSYWAIT}, 32'h0);
        model_reset();
        @(posedge CLK); #1;
        do_access(1'b0, 1'b0, 8'h2C, 8'h00);

        for (int k = 0; k < 200; k++) begin
            a = 8'($urandom);
            a[7:5] = 3'($urandom_range(0, 2));
            d = 8'($urandom);
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 6);
            do_access(wr, rd, a, d);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("cpu_queue_drained", cpu_q.size(), 32'h0);
        chk("mem_queue_drained", mem_q.size(), 32'h0);
`ifdef DCACHE_STATS_EN
        chk("hit_count_final", {16'h0, hit_count}, m_hits);
        chk("miss_count_final", {16'h0, miss_count}, m_miss);
`endif
        summary();
    end

endmodule
`default_nettype wire
